// File: rtl/odo_round_key_sequencer.sv
// Streams Odo round keys for periods 0..N-1 from a one-cycle-latency ROM to a
// valid/ready consumer, using credit-based issue into a 2-entry skid FIFO.
module odo_round_key_sequencer #(
  parameter int MAX_PERIODS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] num_periods,
  output logic [3:0] rom_period,
  input  logic [9:0] rom_key,
  output logic [9:0] key_out,
  output logic [3:0] key_period,
  output logic       key_last,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  typedef struct packed {
    logic [9:0] key;
    logic [3:0] period;
    logic       last;
  } entry_t;

  localparam logic [3:0] MAX_N = 4'(MAX_PERIODS);

  state_t     state_q, state_d;
  logic [3:0] n_q, p_q, rom_period_q, infl_period_q;
  logic       inflight_q, infl_last_q;
  entry_t     fifo_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q;
  logic       done_q, err_q;

  logic   legal, accept, reject, pop, credit, issue, issue_last, finish;
  entry_t head;

  assign head       = fifo_q[rd_ptr_q];
  assign key_valid  = (count_q != 2'd0);
  assign pop        = key_valid & key_ready;
  assign legal      = (num_periods != 4'd0) && (num_periods <= MAX_N);
  assign issue_last = (p_q == n_q - 4'd1);
  // Keys already owed (buffered + on the ROM bus) minus the one leaving now must
  // leave a free slot, so the FIFO can never be written while full.
  assign credit     = (({1'b0, count_q} + {2'b0, inflight_q}) - {2'b0, pop}) < 3'd2;

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    issue   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (legal) begin
            accept  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (credit) begin
          issue = 1'b1;
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head.last) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q           <= '0;
      p_q           <= '0;
      rom_period_q  <= '0;
      inflight_q    <= 1'b0;
      infl_period_q <= '0;
      infl_last_q   <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q     <= finish;
      err_q      <= reject;
      inflight_q <= issue;
      if (accept) begin
        n_q <= num_periods;
        p_q <= '0;
      end else if (issue) begin
        p_q           <= p_q + 4'd1;
        rom_period_q  <= p_q;
        infl_period_q <= p_q;
        infl_last_q   <= issue_last;
      end
    end
  end

  // NOTE: the FIFO storage is reset because its head drives key_out directly
  // and key_out must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= '{key: rom_key, period: infl_period_q, last: infl_last_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign rom_period = issue ? p_q : rom_period_q;
  assign key_out    = head.key;
  assign key_period = head.period;
  assign key_last   = head.last;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_odo_round_key_sequencer.sv
// Self-checking bench: a registered ROM model, a queue-based expectation of
// the key stream per run, and directed cycle-exact pins for the model itself.
module tb_odo_round_key_sequencer;

  localparam logic [9:0] ROM_TAB [10] = '{10'h3ef, 10'h2d9, 10'h2d7, 10'h229, 10'h008,
                                          10'h335, 10'h091, 10'h073, 10'h1ce, 10'h1c6};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_periods = '0;
  logic [3:0] rom_period;
  logic [9:0] rom_key = '0;
  logic [9:0] key_out;
  logic [3:0] key_period;
  logic       key_last, key_valid;
  logic       key_ready = 1'b0;
  logic       busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random

  typedef struct {
    logic [9:0] key;
    logic [3:0] period;
    logic       last;
  } exp_t;

  exp_t exp_q [$];
  bit   exp_busy = 0, exp_done = 0, exp_err = 0;
  int   pops = 0;

  odo_round_key_sequencer #(.MAX_PERIODS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_periods(num_periods),
    .rom_period(rom_period), .rom_key(rom_key),
    .key_out(key_out), .key_period(key_period), .key_last(key_last),
    .key_valid(key_valid), .key_ready(key_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Registered round-key ROM: data appears the cycle after the address.
  always @(posedge clk) rom_key <= (rom_period < 4'd10) ? ROM_TAB[rom_period] : 10'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted start owes keys 0..N-1 in order, exactly once.
  always @(negedge clk) begin
    bit was_busy;
    bit xfer;
    if (!rst_n) begin
      check("rst_rom_period", rom_period, 0);
      check("rst_key_out", key_out, 0);
      check("rst_key_period", key_period, 0);
      check("rst_key_last", key_last, 0);
      check("rst_key_valid", key_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      exp_q.delete();
      exp_busy = 0;
      exp_done = 0;
      exp_err  = 0;
      pops     = 0;
    end else begin
      was_busy = exp_busy;
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("err", err, exp_err);
      xfer = key_valid && key_ready;
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_key", key_valid, 0);
        end else begin
          check("key_out", key_out, exp_q[0].key);
          check("key_period", key_period, exp_q[0].period);
          check("key_last", key_last, exp_q[0].last);
        end
      end
      // Periods issued so far may exceed keys consumed by at most two.
      if (exp_busy) check("credit", int'(rom_period) <= pops + int'(xfer) + 1, 1);
      exp_done = 0;
      exp_err  = 0;
      if (xfer && exp_q.size() > 0) begin
        if (exp_q[0].last) begin
          exp_busy = 0;
          exp_done = 1;
        end
        void'(exp_q.pop_front());
        pops++;
      end
      if (!was_busy && start) begin
        if (num_periods >= 4'd1 && num_periods <= 4'd10) begin
          exp_busy = 1;
          pops     = 0;
          for (int k = 0; k < int'(num_periods); k++)
            exp_q.push_back('{key: ROM_TAB[k], period: 4'(k), last: (k == int'(num_periods) - 1)});
        end else begin
          exp_err = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    case (rdy_mode)
      0:       key_ready = 1'b1;
      1:       key_ready = 1'b0;
      default: key_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic do_start(input logic [3:0] n);
    tick();
    start       = 1'b1;
    num_periods = n;
  endtask

  task automatic run_until_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // N=10, ready high: cycle-exact pins
    rdy_mode = 0;
    do_start(4'd10);
    tick(); @(negedge clk);
    check("c1_busy", busy, 1);
    check("c1_rom_period", rom_period, 0);
    tick(); tick(); @(negedge clk);
    check("c3_valid", key_valid, 1);
    check("c3_key", key_out, 10'h3ef);
    check("c3_period", key_period, 0);
    repeat (9) tick();
    @(negedge clk);
    check("c12_key", key_out, 10'h1c6);
    check("c12_last", key_last, 1);
    check("c12_period", key_period, 9);
    tick(); @(negedge clk);
    check("c13_done", done, 1);
    check("c13_busy", busy, 0);
    check("hold_rom_period", rom_period, 9);

    // N=3, ready low for 10 cycles
    rdy_mode = 1;
    do_start(4'd3);
    repeat (10) tick();
    @(negedge clk);
    check("stall_valid", key_valid, 1);
    check("stall_key", key_out, 10'h3ef);
    check("stall_rom_period", rom_period, 1);
    rdy_mode = 0;
    run_until_done(50);
    tick(); @(negedge clk);
    check("stall_queue_empty", exp_q.size(), 0);

    // N=10, random ready
    rdy_mode = 2;
    do_start(4'd10);
    run_until_done(400);
    rdy_mode = 0;
    tick(); @(negedge clk);
    check("rand_queue_empty", exp_q.size(), 0);

    // Illegal lengths
    do_start(4'd0);
    tick(); @(negedge clk);
    check("err0_err", err, 1);
    check("err0_busy", busy, 0);
    check("err0_rom_period", rom_period, 9);
    do_start(4'd11);
    tick(); @(negedge clk);
    check("err11_err", err, 1);
    check("err11_busy", busy, 0);
    check("err11_rom_period", rom_period, 9);

    // Reset in cycle 5 of an N=10 run
    do_start(4'd10);
    repeat (5) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", key_valid, 0);
    check("midrst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    do_start(4'd2);
    run_until_done(50);

    // Start during busy is ignored; start in the done cycle launches a new run
    do_start(4'd2);
    tick();
    tick();
    start = 1'b1; num_periods = 4'd4;
    tick();
    tick();
    tick();
    start = 1'b1; num_periods = 4'd3;
    @(negedge clk);
    check("b2b_done", done, 1);
    tick(); @(negedge clk);
    check("b2b_busy", busy, 1);
    run_until_done(50);

    // A few random-length runs under random backpressure
    rdy_mode = 2;
    for (int r = 0; r < 4; r++) begin
      do_start(4'($urandom_range(1, 10)));
      run_until_done(400);
    end
    rdy_mode = 0;
    repeat (3) tick();
    @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
